bcd2bin_seq: RTL and testbench

- Multi-cycle BCD-to-binary converter: the decode direction of the team's binary-to-BCD path.
- Accepts a packed DIGITS-digit BCD word over a valid/ready handshake.
- Runs the reverse shift-add-3 algorithm: shift right, then subtract 3 from any digit >= 8. It processes one bit per clock.
- Returns the binary value over a second valid/ready handshake. Used where display/keypad BCD values must be turned back into arithmetic operands.

---
 rtl/bcd2bin_seq_pkg.sv | 20 ++
 rtl/bcd2bin_seq_if.sv | 27 ++
 rtl/bcd2bin_seq_sub3.sv | 12 +
 rtl/bcd2bin_seq.sv | 140 ++++++++++++++
 tb/tb_bcd2bin_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// Shared BCD constants, FSM state type and the digit-legality helper used by
// both the encoder and decoder sides of the BCD path.
package bcd2bin_seq_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned MAX_DIGIT = 9;
  localparam int unsigned CORR      = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // A 4-bit BCD digit is legal only in the range 0..9.
  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Input (BCD word) and output (binary result) valid/ready handshakes of the
// BCD-to-binary converter.
interface bcd2bin_seq_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
);
  import bcd2bin_seq_pkg::*;

  logic                        IN_VALID;
  logic                        IN_READY;
  logic [DIGIT_W*DIGITS-1:0]   BCD;
  logic                        OUT_VALID;
  logic                        OUT_READY;
  logic [BIN_W-1:0]            BIN;
  logic                        BAD_DIGIT;

  modport master (
    output IN_VALID, BCD, OUT_READY,
    input  IN_READY, OUT_VALID, BIN, BAD_DIGIT
  );

  modport slave (
    input  IN_VALID, BCD, OUT_READY,
    output IN_READY, OUT_VALID, BIN, BAD_DIGIT
  );

endinterface

// File: rtl/bcd2bin_seq_sub3.sv
// Combinational correction cell: a digit >= 8 after a right shift has 3
// subtracted; the inverse of the encoder's add-3 cell.
module bcd_sub3
  import bcd2bin_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit_c
);

  assign o_digit_c = (i_digit >= DIGIT_W'(8)) ? (i_digit - DIGIT_W'(CORR)) : i_digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Multi-cycle BCD-to-binary converter: reverse shift/subtract-3, one bit per
// clock, with valid/ready handshakes on both sides.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic          clk,
  input  logic          rst,
  bcd2bin_seq_if.slave  bus
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned TOT_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // The largest DIGITS-digit decimal value must fit in BIN_W bits.
  if ((64'd10 ** DIGITS) - 64'd1 >= (64'd1 << BIN_W)) begin : g_bad_param
    $error("bcd2bin_seq: BIN_W too small to hold 10**DIGITS-1");
  end

  state_e             r_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [BIN_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [BIN_W-1:0]   r_bin_out;
  logic               r_bad;

  state_e             w_state_nx;
  logic [BCD_W-1:0]   w_bcd_nx;
  logic [BIN_W-1:0]   w_bin_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_out_valid_nx;
  logic [BIN_W-1:0]   w_bin_out_nx;
  logic               w_bad_nx;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_any_bad;
  logic [TOT_W-1:0]   w_shift;
  logic [BCD_W-1:0]   w_bcd_sh;
  logic [BIN_W-1:0]   w_bin_sh;
  logic [BCD_W-1:0]   w_bcd_corr;

  assign w_in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept   = bus.IN_VALID && w_in_ready;

  // One shift step: the BCD LSB moves into the binary MSB.
  assign w_shift  = {r_bcd, r_bin} >> 1;
  assign w_bcd_sh = w_shift[TOT_W-1:BIN_W];
  assign w_bin_sh = w_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
    bcd_sub3 u_sub3 (
      .i_digit   (w_bcd_sh[g*DIGIT_W +: DIGIT_W]),
      .o_digit_c (w_bcd_corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    w_any_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (!digit_ok(bus.BCD[d*DIGIT_W +: DIGIT_W])) w_any_bad = 1'b1;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    w_state_nx     = r_state;
    w_bcd_nx       = r_bcd;
    w_bin_nx       = r_bin;
    w_cnt_nx       = r_cnt;
    w_out_valid_nx = r_out_valid;
    w_bin_out_nx   = r_bin_out;
    w_bad_nx       = r_bad;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_any_bad) begin
            w_state_nx     = S_DONE;
            w_bin_out_nx   = '0;
            w_bad_nx       = 1'b1;
            w_out_valid_nx = 1'b1;
          end else begin
            w_state_nx = S_SHIFT;
            w_bcd_nx   = bus.BCD;
            w_bin_nx   = '0;
            w_cnt_nx   = '0;
            w_bad_nx   = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        w_bcd_nx = w_bcd_corr;
        w_bin_nx = w_bin_sh;
        w_cnt_nx = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(BIN_W - 1)) begin
          w_state_nx     = S_DONE;
          w_out_valid_nx = 1'b1;
          w_bin_out_nx   = w_bin_sh;
        end
      end
      S_DONE: begin
        if (bus.OUT_READY) begin
          w_state_nx     = S_IDLE;
          w_out_valid_nx = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bcd       <= '0;
      r_bin       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_bin_out   <= '0;
      r_bad       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bcd       <= w_bcd_nx;
      r_bin       <= w_bin_nx;
      r_cnt       <= w_cnt_nx;
      r_out_valid <= w_out_valid_nx;
      r_bin_out   <= w_bin_out_nx;
      r_bad       <= w_bad_nx;
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.BIN       = r_bin_out;
  assign bus.BAD_DIGIT = r_bad;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: vector table, backpressure, mid-run
// reset and a sweep of every legal 3-digit code.
module tb_bcd2bin_seq;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic clk;
  logic rst;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        bad;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Send one word, wait for the result, optionally stall, then handshake it.
  // lat = edges after the accept edge until OUT_VALID is seen.
  task automatic do_conv(input logic [11:0] bcd, input int stall, input bit rnd,
                         input bit mutate, output logic [9:0] bin, output logic bad,
                         output int lat);
    int w;
    w = 0;
    while (bus.IN_READY !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 32'(bus.IN_READY), 32'd1);
    bus.IN_VALID = 1'b1;
    bus.BCD      = bcd;
    @(posedge clk);
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    lat = 0;
    while (bus.OUT_VALID !== 1'b1 && lat < 40) begin
      if (mutate && lat == 3) bus.BCD = 12'h111;
      bus.OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.OUT_READY = 1'b0;
    chk("out_valid_seen", 32'(bus.OUT_VALID), 32'd1);
    bin = bus.BIN;
    bad = bus.BAD_DIGIT;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("hold_bin", 32'(bus.BIN), 32'(bin));
      chk("hold_bad", 32'(bus.BAD_DIGIT), 32'(bad));
      chk("hold_in_ready", 32'(bus.IN_READY), 32'd0);
    end
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    bus.OUT_READY = 1'b0;
    chk("post_hs_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("post_hs_in_ready", 32'(bus.IN_READY), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  bin;
    logic        bad;
    int          lat;
    logic [11:0] code;

    vecs[0]  = '{12'h999, 10'd999, 1'b0, 10};
    vecs[1]  = '{12'h000, 10'd0,   1'b0, 10};
    vecs[2]  = '{12'h255, 10'd255, 1'b0, 10};
    vecs[3]  = '{12'h001, 10'd1,   1'b0, 10};
    vecs[4]  = '{12'h128, 10'd128, 1'b0, 10};
    vecs[5]  = '{12'h1A5, 10'd0,   1'b1, 0};
    vecs[6]  = '{12'h0F0, 10'd0,   1'b1, 0};
    vecs[7]  = '{12'h042, 10'd42,  1'b0, 10};
    vecs[8]  = '{12'h500, 10'd500, 1'b0, 10};
    vecs[9]  = '{12'h090, 10'd90,  1'b0, 10};
    vecs[10] = '{12'h00A, 10'd0,   1'b1, 0};
    vecs[11] = '{12'hA00, 10'd0,   1'b1, 0};

    // Reset held with IN_VALID high: nothing may be accepted.
    rst           = 1'b1;
    bus.IN_VALID  = 1'b1;
    bus.BCD       = 12'h999;
    bus.OUT_READY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_bin", 32'(bus.BIN), 32'd0);
    chk("rst_bad", 32'(bus.BAD_DIGIT), 32'd0);
    rst          = 1'b0;
    bus.IN_VALID = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.IN_READY), 32'd1);
    @(negedge clk);
    chk("rel_not_accepted", 32'(bus.IN_READY), 32'd1);
    chk("rel_out_valid", 32'(bus.OUT_VALID), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_conv(vecs[i].bcd, 0, 1'b0, 1'b0, bin, bad, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_bin", i), 32'(bin), 32'(vecs[i].bin));
      chk($sformatf("vec%0d_bad", i), 32'(bad), 32'(vecs[i].bad));
    end

    // Backpressure for 6 cycles, BCD changed mid-conversion.
    do_conv(12'h407, 6, 1'b0, 1'b1, bin, bad, lat);
    chk("bp_lat", 32'(lat), 32'd10);
    chk("bp_bin", 32'(bin), 32'd407);
    chk("bp_bad", 32'(bad), 32'd0);

    // Reset during the fourth shift step of 999.
    @(negedge clk);
    chk("mr_ready", 32'(bus.IN_READY), 32'd1);
    bus.IN_VALID = 1'b1;
    bus.BCD      = 12'h999;
    @(posedge clk);
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("mr_bin", 32'(bus.BIN), 32'd0);
    chk("mr_bad", 32'(bus.BAD_DIGIT), 32'd0);
    chk("mr_in_ready_rst", 32'(bus.IN_READY), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_in_ready", 32'(bus.IN_READY), 32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("mr_no_partial", 32'(bus.OUT_VALID), 32'd0);
    end
    do_conv(12'h042, 0, 1'b0, 1'b0, bin, bad, lat);
    chk("mr_next_lat", 32'(lat), 32'd10);
    chk("mr_next_bin", 32'(bin), 32'd42);

    // Every legal 3-digit code (covers the 0..255 round trip) with random stalls.
    for (int v = 0; v < 1000; v++) begin
      code = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      do_conv(code, int'($urandom_range(0, 3)), 1'b1, 1'b0, bin, bad, lat);
      chk($sformatf("rt_bin v=%0d", v), 32'(bin), 32'(v));
      chk($sformatf("rt_bad v=%0d", v), 32'(bad), 32'd0);
      chk($sformatf("rt_lat v=%0d", v), 32'(lat), 32'd10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
